yacht_roll_ctrl: RTL
====================

// Module: yacht_roll_ctrl
// PURPOSE
//  Turn/roll controller directly upstream of the dice manager. Debounces the roll and confirm
//  push-buttons, enforces MAX_ROLLS rolls per turn, and emits roll_en pulse(s) with a hold mask
//  that is forced open on a turn's first roll and frozen during a roll. Ends a turn with a
//  one-cycle turn_end pulse to the scoring stage.
// PARAMETERS
//  DB_W        20         width of debounce counter
//  DB_LIMIT    1_000_000  consecutive equal synced samples to accept a new button level (20 ms @ 50 MHz)
//  MAX_ROLLS   3          rolls per turn, 1..3
//  ANIM_PULSES 8          roll_en pulses per roll when ROLL_ANIM_EN is defined, >=1
//  ANIM_GAP    2_500_000  cycles between animation pulses, >=1
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  async active-low reset
//  btn_roll     in   1  raw roll button, active-high, asynchronous
//  btn_confirm  in   1  raw confirm button, active-high, asynchronous
//  hold_sw_in   in   5  DIP hold switches, bit i = die i+1 held
//  roll_en      out  1  to dice manager: one-cycle roll strobe(s)
//  hold_sw_out  out  5  to dice manager: effective hold mask
//  roll_cnt     out  2  rolls completed in current turn, 0..MAX_ROLLS
//  busy         out  1  high while in ANIM
//  turn_end     out  1  one-cycle pulse: turn confirmed
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, roll_en=0, hold_sw_out=0, roll_cnt=0, busy=0, turn_end=0,
//   synchronizers, debounced levels and all counters 0. Reset mid-ANIM aborts the roll; no further pulses.
//  Input path per button: 2-FF synchronizer -> counter; counter clears when synced==debounced, else
//   increments; at DB_LIMIT debounced level takes synced value. press = debounced rising edge, 1 cycle.
//  FSM:
//   IDLE:   hold_sw_out=5'b0. roll press -> ANIM. confirm press ignored.
//   ANIM:   busy=1. hold mask latched from hold_sw_in (IDLE: 0) on entry; held constant throughout.
//           pulse counter p=0, gap counter g=0 on entry; roll_en=1 in cycles where g==0; g counts
//           0..ANIM_GAP-1 then wraps, p increments on each pulse. Cycle after pulse ANIM_PULSES:
//           roll_cnt+=1, -> LOCKED if new roll_cnt==MAX_ROLLS else WAIT. All presses during ANIM discarded.
//   WAIT:   hold_sw_out follows hold_sw_in. confirm press -> END. roll press -> ANIM unless
//           hold_sw_in==5'h1F (all held: press ignored, no roll consumed).
//   LOCKED: hold_sw_out follows hold_sw_in; roll press ignored; confirm press -> END.
//   END:    turn_end=1 for exactly this cycle; roll_cnt<=0; -> IDLE.
//  Simultaneous roll+confirm press same cycle: WAIT -> confirm wins; IDLE -> roll wins.
//  Latency: press pulse at cycle t -> state ANIM and first roll_en at t+1.
//  roll_cnt never exceeds MAX_ROLLS; it only clears in END or reset.
// CONFIGURATION
//  ROLL_ANIM_EN defined:   each roll issues ANIM_PULSES roll_en pulses spaced ANIM_GAP cycles
//                          (visible tumbling on the 7-seg display).
//  ROLL_ANIM_EN undefined: each roll issues exactly one roll_en pulse; ANIM lasts 1 cycle;
//                          ANIM_PULSES/ANIM_GAP unused.
// TESTING (DB_LIMIT=4, ANIM_PULSES=4, ANIM_GAP=3, MAX_ROLLS=3, ROLL_ANIM_EN defined)
//  Bounce: btn_roll toggles every 2 cycles x10, then high 10 cycles -> exactly one roll, 4 roll_en
//   pulses 3 cycles apart, roll_cnt 0->1, busy high 12 cycles.
//  First roll with hold_sw_in=5'b10101 in IDLE -> hold_sw_out=5'b00000 for all pulses; 2nd roll with
//   same switches -> hold_sw_out=5'b10101; toggling switches mid-ANIM leaves mask unchanged.
//  Three rolls -> roll_cnt=3, LOCKED; 4th roll press -> no roll_en; confirm -> turn_end 1 cycle,
//   roll_cnt=0, IDLE.
//  Confirm in IDLE -> no turn_end; hold_sw_in=5'h1F in WAIT + roll -> no roll_en, roll_cnt unchanged;
//   roll+confirm same cycle in WAIT -> turn_end, no roll_en.
//  reset_n low during 2nd animation pulse -> all outputs 0 same cycle; after release no roll_en
//   until new debounced press.
//  ROLL_ANIM_EN undefined build: roll press -> single roll_en, busy 1 cycle, roll_cnt+1 next cycle.

Source files
------------

// File: rtl/yacht_roll_ctrl_if.sv
// Button, hold-switch and dice-manager signals of the yacht turn/roll controller.
// The master modport drives the buttons and switches. The slave modport is the controller itself.
interface yacht_roll_ctrl_if;
  logic       btn_roll;
  logic       btn_confirm;
  logic [4:0] hold_sw_in;
  logic       roll_en;
  logic [4:0] hold_sw_out;
  logic [1:0] roll_cnt;
  logic       busy;
  logic       turn_end;

  modport master (
    output btn_roll, btn_confirm, hold_sw_in,
    input  roll_en, hold_sw_out, roll_cnt, busy, turn_end
  );

  modport slave (
    input  btn_roll, btn_confirm, hold_sw_in,
    output roll_en, hold_sw_out, roll_cnt, busy, turn_end
  );
endinterface

// File: rtl/yacht_roll_ctrl.sv
// Turn/roll controller: debounced buttons, MAX_ROLLS per turn, roll_en strobes with a frozen hold mask.
// Latency: a debounced press in cycle t gives the first roll_en in t+1. No backpressure. ROLL_ANIM_EN selects multi-pulse animation.
module yacht_roll_ctrl #(
  parameter int DB_W        = 20,
  parameter int DB_LIMIT    = 1_000_000,
  parameter int MAX_ROLLS   = 3,
  parameter int ANIM_PULSES = 8,
  parameter int ANIM_GAP    = 2_500_000
) (
  input  logic              clk,
  input  logic              reset_n,
  yacht_roll_ctrl_if.slave  bus
);

  if (MAX_ROLLS < 1 || MAX_ROLLS > 3 || ANIM_PULSES < 1 || ANIM_GAP < 1 || DB_LIMIT < 1) begin : g_bad_cfg
    $error("yacht_roll_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ANIM, S_WAIT, S_LOCKED, S_END} state_t;

  // Index 0 = roll button, index 1 = confirm button.
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      press;

  state_t          state_q, state_d;
  logic [1:0]      roll_cnt_q, roll_cnt_d, roll_cnt_inc;
  logic [4:0]      mask_q, mask_d;
  logic            pulse_now, anim_done;

  logic            roll_en_c, busy_c, turn_end_c;
  logic [4:0]      hold_out_c;

  always_comb begin
    sync1_d   = {bus.btn_confirm, bus.btn_roll};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_LIMIT - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    press = deb_q & ~deb_dly_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

`ifdef ROLL_ANIM_EN
  localparam int PW = $clog2(ANIM_PULSES + 1);
  localparam int GW = (ANIM_GAP > 1) ? $clog2(ANIM_GAP) : 1;

  logic [PW-1:0] pulse_q, pulse_d;
  logic [GW-1:0] gap_q, gap_d;

  // Counters idle at zero outside ANIM so every roll starts with a pulse.
  always_comb begin
    pulse_now = (gap_q == '0);
    anim_done = (gap_q == GW'(ANIM_GAP - 1)) &&
                ((pulse_q + PW'(pulse_now)) == PW'(ANIM_PULSES));
    pulse_d   = '0;
    gap_d     = '0;
    if (state_q == S_ANIM) begin
      pulse_d = pulse_q + PW'(pulse_now);
      gap_d   = (gap_q == GW'(ANIM_GAP - 1)) ? '0 : gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
      gap_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
    end
  end
`else
  always_comb begin
    pulse_now = 1'b1;
    anim_done = 1'b1;
  end
`endif

  always_comb begin
    state_d      = state_q;
    roll_cnt_d   = roll_cnt_q;
    mask_d       = mask_q;
    roll_cnt_inc = roll_cnt_q + 2'd1;
    roll_en_c    = 1'b0;
    busy_c       = 1'b0;
    turn_end_c   = 1'b0;
    hold_out_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          state_d = S_ANIM;
          mask_d  = '0;
        end
      end
      S_ANIM: begin
        busy_c     = 1'b1;
        roll_en_c  = pulse_now;
        hold_out_c = mask_q;
        if (anim_done) begin
          roll_cnt_d = roll_cnt_inc;
          state_d    = (roll_cnt_inc == 2'(MAX_ROLLS)) ? S_LOCKED : S_WAIT;
        end
      end
      S_WAIT: begin
        hold_out_c = bus.hold_sw_in;
        // Confirm beats roll; an all-held roll is ignored without using up a roll.
        if (press[1]) begin
          state_d = S_END;
        end else if (press[0] && bus.hold_sw_in != 5'h1F) begin
          state_d = S_ANIM;
          mask_d  = bus.hold_sw_in;
        end
      end
      S_LOCKED: begin
        hold_out_c = bus.hold_sw_in;
        if (press[1]) state_d = S_END;
      end
      S_END: begin
        turn_end_c = 1'b1;
        roll_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      roll_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      roll_cnt_q <= roll_cnt_d;
      mask_q     <= mask_d;
    end
  end

  assign bus.roll_en     = roll_en_c;
  assign bus.busy        = busy_c;
  assign bus.turn_end    = turn_end_c;
  assign bus.hold_sw_out = hold_out_c;
  assign bus.roll_cnt    = roll_cnt_q;

endmodule
